// File: rtl/paddle_ai.sv
// Paddle controller: waits a reaction delay when the ball approaches, then strobes up/down
// requests toward the ball. Define PADDLE_AI_MISS_EN to add LFSR-driven deliberate misses.
module paddle_ai #(
    parameter int oHeight    = 150,
    parameter int deadBand   = 8,
    parameter int reactDelay = 16,
    parameter int moveDiv    = 4
) (
    input  logic        PixelClock,
    input  logic        Reset,
    input  logic        aiEnable,
    input  logic        ballToward,
    input  logic [10:0] ballPosY,
    input  logic [10:0] padPosY,
    output logic [1:0]  butCont,
    output logic [1:0]  aiState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        TRACK = 2'd2,
        MISS  = 2'd3
    } state_t;

    localparam logic [7:0]         REACT_LAST = 8'(reactDelay);
    localparam logic [7:0]         DIV_LAST   = 8'(moveDiv - 1);
    localparam logic signed [12:0] HALF_H     = 13'(oHeight / 2);
    localparam logic signed [12:0] POS_DB     = 13'(deadBand);
    localparam logic signed [12:0] NEG_DB     = 13'(-deadBand);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_react;
    logic [7:0]         r_div;
    logic [1:0]         r_but;
    logic [1:0]         w_req;
    logic               w_active;
    logic               w_wait_done;
    logic               w_strobe;
    logic signed [12:0] w_centre;
    logic signed [12:0] w_ball;
    logic signed [12:0] w_diff;

`ifdef PADDLE_AI_MISS_EN
    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
`endif

    assign w_active    = aiEnable & ballToward;
    assign w_wait_done = (r_react == REACT_LAST);

    // One bit wider than the 12-bit signed range so padPosY near 2047 plus half height cannot wrap.
    assign w_centre = signed'(13'(padPosY)) + HALF_H;
    assign w_ball   = signed'(13'(ballPosY));
    assign w_diff   = w_centre - w_ball;

    always_comb begin
        // NOTE: defaults first so every path assigns w_req and no latch is inferred.
        w_req = 2'b00;
        if (w_diff > POS_DB)
            w_req = 2'b10;
        else if (w_diff < NEG_DB)
            w_req = 2'b01;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_active) w_next = WAIT;
`ifdef PADDLE_AI_MISS_EN
            WAIT:    if (w_wait_done) w_next = (r_lfsr[2:0] == 3'b000) ? MISS : TRACK;
`else
            WAIT:    if (w_wait_done) w_next = TRACK;
`endif
            TRACK:   w_next = TRACK;
            MISS:    w_next = MISS;
            default: w_next = IDLE;
        endcase
        if (!w_active)
            w_next = IDLE;
    end

    // A request only leaves the block if TRACK continues, so butCont is 00 whenever state is not TRACK.
    assign w_strobe = (r_state == TRACK) && (w_next == TRACK) && (r_div == 8'd0);

    always_ff @(posedge PixelClock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_react <= 8'd0;
            r_div   <= 8'd0;
            r_but   <= 2'b00;
`ifdef PADDLE_AI_MISS_EN
            r_lfsr  <= 8'hA5;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            r_react <= (r_state == WAIT) ? r_react + 8'd1 : 8'd0;
            if (r_state == TRACK)
                r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
            else
                r_div <= 8'd0;
            r_but   <= w_strobe ? w_req : 2'b00;
`ifdef PADDLE_AI_MISS_EN
            r_lfsr  <= {r_lfsr[6:0], w_fb};
`endif
        end
    end

    assign butCont = r_but;
    assign aiState = r_state;

endmodule

// File: tb/tb_paddle_ai.sv
// Directed bench for paddle_ai: reset, reaction delay, strobe cadence, deadband edges and
// coordinate extremes; with PADDLE_AI_MISS_EN, MISS entries against a reference LFSR.
module tb_paddle_ai;

    logic        clk;
    logic        rst;
    logic        en0, tow0, en1, tow1;
    logic [10:0] pad0, ball0, pad1, ball1;
    logic [1:0]  but0, st0, but1, st1;

    int n_checks = 0;
    int n_errors = 0;
    int trk_t    = 0;
    logic saw3   = 1'b0;

    typedef struct {
        string       name;
        logic [10:0] pad;
        logic [10:0] ball;
        logic [1:0]  exp;
    } vec_t;

    vec_t vecs[12];

    paddle_ai u_dut (
        .PixelClock (clk),
        .Reset      (rst),
        .aiEnable   (en0),
        .ballToward (tow0),
        .ballPosY   (ball0),
        .padPosY    (pad0),
        .butCont    (but0),
        .aiState    (st0)
    );

    paddle_ai #(.moveDiv(1)) u_dut1 (
        .PixelClock (clk),
        .Reset      (rst),
        .aiEnable   (en1),
        .ballToward (tow1),
        .ballPosY   (ball1),
        .padPosY    (pad1),
        .butCont    (but1),
        .aiState    (st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (st0 == 2'd3 || st1 == 2'd3) saw3 = 1'b1;

`ifdef PADDLE_AI_MISS_EN
    logic [7:0] m_lfsr;
    always @(posedge clk)
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe output for TRACK cycle t comes from the divider-zero cycle t-1, i.e. t = 2, 6, 10, ...
    task automatic track_cycles(input int n, input logic [1:0] req);
        for (int i = 0; i < n; i++) begin
            step();
            trk_t++;
            check("track_state", st0, 2'd2);
            check("track_but", but0, ((trk_t - 2) % 4 == 0) ? req : 2'b00);
        end
    endtask

    initial begin
        // centre = pad + 75
        vecs[0]  = '{"far_up",      11'd225,  11'd100,  2'b10};
        vecs[1]  = '{"far_down",    11'd225,  11'd500,  2'b01};
        vecs[2]  = '{"inside_db",   11'd225,  11'd304,  2'b00};
        vecs[3]  = '{"db_eq_down",  11'd225,  11'd308,  2'b00};
        vecs[4]  = '{"db_out_down", 11'd225,  11'd309,  2'b01};
        vecs[5]  = '{"db_eq_up",    11'd225,  11'd292,  2'b00};
        vecs[6]  = '{"db_out_up",   11'd225,  11'd291,  2'b10};
        vecs[7]  = '{"pad0_ballmax",11'd0,    11'd2047, 2'b01};
        vecs[8]  = '{"padmax_ball0",11'd2047, 11'd0,    2'b10};
        vecs[9]  = '{"both_zero",   11'd0,    11'd0,    2'b10};
        vecs[10] = '{"centre_eq",   11'd1972, 11'd2047, 2'b00};
        vecs[11] = '{"both_max",    11'd2047, 11'd2047, 2'b10};

        rst = 1'b1;
        en0 = 1'b1; tow0 = 1'b1; pad0 = 11'h7FF; ball0 = 11'h7FF;
        en1 = 1'b0; tow1 = 1'b0; pad1 = 11'd0;   ball1 = 11'd0;

        // Reset held with all inputs high
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_state", st0, 2'd0);
            check("rst_but", but0, 2'b00);
        end
        rst = 1'b0;
        step();
        check("rst_release_wait", st0, 2'd1);

`ifndef PADDLE_AI_MISS_EN
        // Reaction delay then upward strobes every 4th cycle
        rst = 1'b1; pad0 = 11'd225; ball0 = 11'd100;
        step();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            check("wait_state", st0, 2'd1);
            check("wait_but", but0, 2'b00);
        end
        step();
        trk_t = 1;
        check("track_entry_state", st0, 2'd2);
        check("track_entry_but", but0, 2'b00);
        track_cycles(12, 2'b10);
        ball0 = 11'd500;
        track_cycles(8, 2'b01);
        ball0 = 11'd304;
        track_cycles(8, 2'b00);

        // Divider is at 0 here with an up request pending; dropping ballToward must suppress it
        ball0 = 11'd100; tow0 = 1'b0;
        step();
        check("drop_idle_state", st0, 2'd0);
        check("drop_idle_but", but0, 2'b00);
        tow0 = 1'b1;
        step();
        check("rewait_state", st0, 2'd1);
        check("rewait_but", but0, 2'b00);
        for (int i = 0; i < 16; i++) begin
            step();
            check("rewait_state", st0, 2'd1);
        end
        step();
        trk_t = 1;
        check("retrack_state", st0, 2'd2);
        track_cycles(4, 2'b10);

        // Reset in TRACK while a strobe is due
        rst = 1'b1;
        step();
        check("rst_track_state", st0, 2'd0);
        check("rst_track_but", but0, 2'b00);
        step();
        check("rst_hold_state", st0, 2'd0);
        rst = 1'b0;
        step();
        check("rst_leave_state", st0, 2'd1);
        en0 = 1'b0;

        // moveDiv=1 instance: table of deadband and extreme-coordinate vectors
        en1 = 1'b1; tow1 = 1'b1; pad1 = 11'd225; ball1 = 11'd100;
        for (int i = 0; i < 17; i++) step();
        check("div1_wait_last", st1, 2'd1);
        step();
        check("div1_track_state", st1, 2'd2);
        check("div1_track_but", but1, 2'b00);
        for (int i = 0; i < 12; i++) begin
            pad1  = vecs[i].pad;
            ball1 = vecs[i].ball;
            step();
            check(vecs[i].name, but1, vecs[i].exp);
            check("div1_state", st1, 2'd2);
        end
        pad1 = 11'd0; ball1 = 11'd2047;
        for (int i = 0; i < 10; i++) begin
            step();
            check("div1_extreme_down", but1, 2'b01);
        end
        check("no_miss_state", {1'b0, saw3}, 2'b00);
`else
        // Repeated approaches; each WAIT exit must match the reference LFSR low bits
        begin
            logic [7:0] pl;
            logic [1:0] ps;
            rst = 1'b1; pad0 = 11'd225; ball0 = 11'd100;
            step();
            rst = 1'b0;
            for (int c = 0; c < 200; c++) begin
                tow0 = (c % 25 != 24);
                pl = m_lfsr;
                ps = st0;
                step();
                if (ps == 2'd1 && st0 != 2'd1 && st0 != 2'd0)
                    check("miss_entry", st0, (pl[2:0] == 3'b000) ? 2'd3 : 2'd2);
                if (st0 == 2'd3)
                    check("miss_but", but0, 2'b00);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
